ram_data_master: RTL and testbench
==================================

# ram_data_master

Initiator-side bridge between the core's data-bus handshake (req/gnt/rvalid) and the byte-addressed RAM data port of the Verilator model. It splits an arbitrary 4-bit byte-enable request into a sequence of RAM accesses: full word, aligned halfword (0011/1100) or single byte. It sends those accesses with the byte address of each segment, collects the lane-aligned read data, and returns one response per request. It sits in the testbench top between the core LSU and RAM port b.

## Interface
- ADDR_WIDTH, 8: RAM byte-address width.
- STALL_EN, 0: 1 enables pseudo-random grant withholding, for verification.
- LFSR_SEED, 8'hA5: reset value of the stall LFSR. Must be nonzero.

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- data_req_i  in  1  request valid
- data_gnt_o  out  1  request accepted this cycle
- data_rvalid_o  out  1  response valid, one cycle pulse
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_we_i  in  1  1 = write
- data_be_i  in  4  lane byte enables
- data_wdata_i  in  32  lane-aligned write data
- data_rdata_o  out  32  lane-aligned read data; disabled lanes are 0
- ram_en_o  out  1  RAM access strobe
- ram_addr_o  out  ADDR_WIDTH  segment byte address
- ram_we_o  out  1  RAM write
- ram_be_o  out  4  segment pattern
- ram_wdata_o  out  32  equals the registered/incoming wdata, lanes preserved
- ram_rdata_i  in  32  RAM read data, 1-cycle latency

## Operation
- Segmentation scans the remaining mask from lane 0 upward at the lowest set lane i:
  - Mask 1111 → one full-word segment.
  - Otherwise i even and lane i+1 set → halfword segment (0011 or 1100).
  - Otherwise → single-byte segment 1<<i.
  - The segment's lanes are cleared and the scan repeats.
- Segments per request N ∈ 1..4. Example: 0110 → 0010, 0100. 1011 → 0011, 1000.
- Segment address = {data_addr[ADDR_WIDTH-1:2], 2'b00} + i. Addresses above 2^ADDR_WIDTH are truncated, wrapping modulo the RAM size.
- FSM states:
  - IDLE: data_gnt_o = data_req_i && !stall.
    - On grant, segment 0 is driven combinationally from the inputs in the same cycle.
    - addr, we, be and wdata are captured, along with the remaining mask.
    - If N>1, go to BUSY. Otherwise stay in IDLE.
  - BUSY: data_gnt_o=0. Issue one segment per cycle from the registered mask. After the last segment, go to IDLE.
- Reads: the RAM data captured one cycle after each segment is merged into an accumulator, only on that segment's lanes. data_rdata_o = accumulator & lane-mask of data_be.
- Writes: data_rdata_o = 0.
- be=0000: granted, no ram_en_o, rvalid the next cycle with rdata 0.
- Stall: when STALL_EN=1, an 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle. stall = lfsr[0], and it is evaluated only in IDLE. When STALL_EN=0, stall = 0.
- Protocol rules: the core must not change request inputs while req=1 && gnt=0. The RAM must return data exactly one cycle after ram_en_o.

## Timing
- Request granted in cycle 0 with N segments: segments in cycles 0..N-1, data_rvalid_o in cycle N.
- Back-to-back requests: a new grant is possible in cycle N, the same cycle as the previous rvalid. Throughput is N cycles per request.
- ram_en_o is high exactly in segment cycles.
- Reset (async assert, any state):
  - State IDLE.
  - All outputs 0.
  - Accumulator 0.
  - LFSR = LFSR_SEED.
  - An in-flight request is dropped with no rvalid.
- Deassertion is synchronous to clk, via the external synchronizer.

## Structure
- Shared package ram_bridge_pkg holds:
  - state_e {IDLE, BUSY}
  - the segment struct {be[3:0], offset[1:0], rest[3:0]}
  - the LFSR taps constant
- Sub-module ram_be_split: purely combinational. Input: remaining mask. Output: segment struct. Instantiated once, and muxed between the input and registered masks.

## Test plan
- Write 0x100, be 1111, 0xDEADBEEF. Then read 0x100 → one ram_en each. rvalid in cycle 1 with rdata 0xDEADBEEF.
- Write 0x20, be 0110, 0xAABBCCDD → RAM accesses 0x21/0010 then 0x22/0100. gnt low in cycle 1, rvalid in cycle 2. A full read then returns 0xXXBBCCXX with unchanged outer bytes.
- Memory word 0x44332211 at 0x40, read with be 0101 → rdata 0x00330011, rvalid in cycle 2.
- Request with be 0000 → no ram_en_o, rvalid in cycle 1, rdata 0.
- Read with be 1011, rst_n asserted in cycle 1 → all outputs 0 immediately, no rvalid. A subsequent word read completes normally.
- STALL_EN=1, 1000 random back-to-back requests (random be including 0000 and wrap addresses) vs. scoreboard:
  - exactly one rvalid per grant, in order
  - data matches
  - gnt is never high in BUSY

Source files
------------

// File: rtl/ram_bridge_pkg.sv
// rtl/ram_bridge_pkg.sv - shared types and constants for the RAM data-port bridge
package ram_bridge_pkg;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [3:0] be;
    logic [1:0] offset;
    logic [3:0] rest;
  } seg_t;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/ram_be_split.sv
// rtl/ram_be_split.sv - picks the next RAM segment from a remaining byte-enable mask
module ram_be_split
  import ram_bridge_pkg::*;
(
  input  logic [3:0] mask,
  output seg_t       seg
);

  logic [3:0] be;
  logic [1:0] offset;

  // Lowest set lane wins; pairs only merge on an even lane boundary
  always_comb begin
    be     = 4'b0000;
    offset = 2'd0;
    if (mask == 4'b1111) begin
      be = 4'b1111;
    end else if (mask[0]) begin
      be = mask[1] ? 4'b0011 : 4'b0001;
    end else if (mask[1]) begin
      be     = 4'b0010;
      offset = 2'd1;
    end else if (mask[2]) begin
      be     = mask[3] ? 4'b1100 : 4'b0100;
      offset = 2'd2;
    end else if (mask[3]) begin
      be     = 4'b1000;
      offset = 2'd3;
    end
  end

  assign seg = {be, offset, mask & ~be};

endmodule

// File: rtl/ram_data_master.sv
// rtl/ram_data_master.sv - splits core data-bus requests into word/halfword/byte RAM accesses
module ram_data_master
  import ram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  state_e                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [3:0]            rest_q;
  logic [31:0]           wdata_q;
  logic [31:0]           acc_q;
  logic                  rvalid_q;
  logic                  rd_pend_q;
  logic [3:0]            rd_lanes_q;
  logic [7:0]            lfsr_q;

  logic                  idle, stall, issue, last;
  logic [ADDR_WIDTH-1:0] base_in, base;
  logic [31:0]           rd_mask, acc_merged;
  seg_t                  seg;
  logic                  unused_addr;

  assign unused_addr = ^{data_addr_i[31:ADDR_WIDTH], data_addr_i[1:0]};

  assign idle    = (state == IDLE);
  assign stall   = STALL_EN ? lfsr_q[0] : 1'b0;
  // Gated by rst_n so every output drops the moment reset asserts
  assign data_gnt_o = rst_n && idle && data_req_i && !stall;
  assign base_in = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign base    = idle ? base_in : base_q;

  ram_be_split u_split (
    .mask (idle ? data_be_i : rest_q),
    .seg  (seg)
  );

  assign issue = idle ? (data_gnt_o && (seg.be != 4'b0000)) : 1'b1;
  assign last  = (idle ? data_gnt_o : 1'b1) && (seg.rest == 4'b0000);

  assign ram_en_o    = issue;
  assign ram_addr_o  = issue ? base + ADDR_WIDTH'(seg.offset) : '0;
  assign ram_we_o    = issue && (idle ? data_we_i : we_q);
  assign ram_be_o    = issue ? seg.be : 4'b0000;
  assign ram_wdata_o = issue ? (idle ? data_wdata_i : wdata_q) : 32'h0;

  // The last segment's data arrives in the rvalid cycle, so merge it on the fly
  assign rd_mask       = lane_mask(rd_lanes_q);
  assign acc_merged    = rd_pend_q ? ((acc_q & ~rd_mask) | (ram_rdata_i & rd_mask)) : acc_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = (rvalid_q && !we_q) ? (acc_merged & lane_mask(be_q)) : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      rest_q     <= 4'b0000;
      wdata_q    <= 32'h0;
      acc_q      <= 32'h0;
      rvalid_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_lanes_q <= 4'b0000;
      lfsr_q     <= LFSR_SEED;
    end else begin
      if (STALL_EN) begin
        lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      end
      rvalid_q   <= last;
      rd_pend_q  <= issue && !ram_we_o;
      rd_lanes_q <= seg.be;
      acc_q      <= acc_merged;
      case (state)
        IDLE: begin
          if (data_gnt_o) begin
            base_q  <= base_in;
            we_q    <= data_we_i;
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
            rest_q  <= seg.rest;
            if (seg.rest != 4'b0000) state <= BUSY;
          end
        end
        BUSY: begin
          rest_q <= seg.rest;
          if (seg.rest == 4'b0000) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_data_master.sv
// tb/tb_ram_data_master.sv - directed and scoreboard bench for ram_data_master
module tb_ram_data_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, rvalid, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [64];
  logic [31:0] sb_mem [64];

  int          vectors = 0;
  int          miscompares = 0;
  int          nseg, rv_cyc, gnt_busy;
  logic [7:0]  seg_addr [4];
  logic [3:0]  seg_be [4];
  logic [31:0] rv_data;

  always #5 clk = ~clk;

  ram_data_master #(
    .ADDR_WIDTH (8),
    .STALL_EN   (1'b1),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_rvalid_o (rvalid),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_rdata_o  (rdata),
    .ram_en_o      (ram_en),
    .ram_addr_o    (ram_addr),
    .ram_we_o      (ram_we),
    .ram_be_o      (ram_be),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata)
  );

  // RAM port b: word array, byte lanes, one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      for (int k = 0; k < 4; k++)
        if (ram_we && ram_be[k]) mem[ram_addr[7:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
      ram_rdata <= mem[ram_addr[7:2]];
    end
  end

  function automatic logic [31:0] bytes_of(input logic [3:0] b);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) if (b[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic int exp_nseg(input logic [3:0] b);
    int lo, hi;
    if (b == 4'hF) return 1;
    lo = (b[1:0] == 2'b11) ? 1 : int'(b[0]) + int'(b[1]);
    hi = (b[3:2] == 2'b11) ? 1 : int'(b[2]) + int'(b[3]);
    return lo + hi;
  endfunction

  task automatic run_req(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    int t, cyc;
    @(posedge clk); #1;
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    nseg = 0; rv_cyc = -1; gnt_busy = 0; rv_data = 32'h0;
    for (int i = 0; i < 4; i++) begin seg_addr[i] = 8'h0; seg_be[i] = 4'h0; end
    t = 0;
    @(negedge clk);
    while (!gnt && t < 50) begin @(negedge clk); t++; end
    if (!gnt) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: no gnt within 50 cycles for addr %h be %b", a, b);
      req = 1'b0;
      return;
    end
    cyc = 0;
    while (cyc < 10) begin
      if (ram_en) begin
        if (nseg < 4) begin seg_addr[nseg] = ram_addr; seg_be[nseg] = ram_be; end
        nseg++;
      end
      if (cyc > 0 && gnt) gnt_busy++;
      if (rvalid) begin rv_cyc = cyc; rv_data = rdata; break; end
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({gnt, rvalid, ram_en, ram_we, ram_be} !== 8'h0 || rdata !== 32'h0 || ram_addr !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b ram_en=%b rdata=%h ram_addr=%h, required all 0", gnt, rvalid, ram_en, rdata, ram_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rvalid, ram_en} !== 2'b00 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_idle: rvalid=%b ram_en=%b rdata=%h, required 0", rvalid, ram_en, rdata);
    end
  endtask

  task automatic test_word;
    run_req(32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
    vectors++;
    if (nseg !== 1 || {seg_addr[0], seg_be[0]} !== {8'h00, 4'hF} || rv_cyc !== 1 || rv_data !== 32'h0) begin
      miscompares++;
      $display("FAIL word_write: nseg=%0d seg=%h/%b rv_cyc=%0d rdata=%h, required 1 00/1111 1 00000000", nseg, seg_addr[0], seg_be[0], rv_cyc, rv_data);
    end
    run_req(32'h100, 1'b0, 4'hF, 32'h0);
    vectors++;
    if (nseg !== 1 || rv_cyc !== 1) begin
      miscompares++;
      $display("FAIL word_read_timing: nseg=%0d rv_cyc=%0d, required 1 1", nseg, rv_cyc);
    end
    vectors++;
    if (rv_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_read_data: got %h required deadbeef", rv_data);
    end
  endtask

  task automatic test_split_write;
    run_req(32'h20, 1'b1, 4'hF, 32'h11223344);
    run_req(32'h20, 1'b1, 4'b0110, 32'hAABBCCDD);
    vectors++;
    if (nseg !== 2 || {seg_addr[0], seg_be[0], seg_addr[1], seg_be[1]} !== {8'h21, 4'b0010, 8'h22, 4'b0100}) begin
      miscompares++;
      $display("FAIL split_segments: nseg=%0d %h/%b %h/%b, required 2 21/0010 22/0100", nseg, seg_addr[0], seg_be[0], seg_addr[1], seg_be[1]);
    end
    vectors++;
    if (rv_cyc !== 2 || gnt_busy !== 0) begin
      miscompares++;
      $display("FAIL split_timing: rv_cyc=%0d gnt_busy=%0d, required 2 0", rv_cyc, gnt_busy);
    end
    run_req(32'h20, 1'b0, 4'hF, 32'h0);
    vectors++;
    if (rv_data !== 32'h11BBCC44) begin
      miscompares++;
      $display("FAIL split_readback: got %h required 11bbcc44", rv_data);
    end
  endtask

  task automatic test_sparse_read;
    run_req(32'h40, 1'b1, 4'hF, 32'h44332211);
    run_req(32'h40, 1'b0, 4'b0101, 32'h0);
    vectors++;
    if (nseg !== 2 || {seg_addr[0], seg_be[0], seg_addr[1], seg_be[1]} !== {8'h40, 4'b0001, 8'h42, 4'b0100} || rv_cyc !== 2) begin
      miscompares++;
      $display("FAIL sparse_segments: nseg=%0d %h/%b %h/%b rv_cyc=%0d, required 2 40/0001 42/0100 2", nseg, seg_addr[0], seg_be[0], seg_addr[1], seg_be[1], rv_cyc);
    end
    vectors++;
    if (rv_data !== 32'h00330011) begin
      miscompares++;
      $display("FAIL sparse_data: got %h required 00330011", rv_data);
    end
    run_req(32'h40, 1'b0, 4'b1011, 32'h0);
    vectors++;
    if (nseg !== 2 || {seg_addr[0], seg_be[0], seg_addr[1], seg_be[1]} !== {8'h40, 4'b0011, 8'h43, 4'b1000} || rv_data !== 32'h44002211) begin
      miscompares++;
      $display("FAIL be1011_read: nseg=%0d %h/%b %h/%b rdata=%h, required 2 40/0011 43/1000 44002211", nseg, seg_addr[0], seg_be[0], seg_addr[1], seg_be[1], rv_data);
    end
  endtask

  task automatic test_zero_be;
    run_req(32'h80, 1'b0, 4'b0000, 32'hFFFFFFFF);
    vectors++;
    if (nseg !== 0 || rv_cyc !== 1 || rv_data !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_be: nseg=%0d rv_cyc=%0d rdata=%h, required 0 1 00000000", nseg, rv_cyc, rv_data);
    end
  endtask

  task automatic test_reset_inflight;
    int t, seen;
    @(posedge clk); #1;
    req = 1'b1; addr = 32'h40; we = 1'b0; be = 4'b1011; wdata = 32'h0;
    t = 0;
    @(negedge clk);
    while (!gnt && t < 50) begin @(negedge clk); t++; end
    vectors++;
    if (!gnt) begin
      miscompares++;
      $display("FAIL reset_inflight_grant: no gnt within 50 cycles");
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, rvalid, ram_en, ram_we, ram_be} !== 8'h0 || ram_addr !== 8'h0 || ram_wdata !== 32'h0 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_inflight_outputs: gnt=%b rvalid=%b ram_en=%b ram_addr=%h ram_be=%b rdata=%h, required all 0", gnt, rvalid, ram_en, ram_addr, ram_be, rdata);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (rvalid) seen++; end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
    @(negedge clk); if (rvalid) seen++;
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_inflight_rvalid: got %0d rvalid pulses required 0", seen);
    end
    run_req(32'h40, 1'b0, 4'hF, 32'h0);
    vectors++;
    if (rv_cyc !== 1 || rv_data !== 32'h44332211) begin
      miscompares++;
      $display("FAIL after_reset_read: rv_cyc=%0d rdata=%h, required 1 44332211", rv_cyc, rv_data);
    end
  endtask

  task automatic test_back_to_back;
    int          cy, sent, busy_until, en_cnt, en_exp, n, c;
    logic        g;
    logic [31:0] d, mk;
    int          q_cyc [$];
    logic [31:0] q_data [$];
    cy = 0; sent = 0; busy_until = 0; en_cnt = 0; en_exp = 0;
    for (int i = 0; i < 64; i++) sb_mem[i] = mem[i];
    @(posedge clk); #1;
    addr = $urandom; we = 1'($urandom_range(0, 1)); be = 4'($urandom_range(0, 15)); wdata = $urandom;
    req = 1'b1;
    while ((sent < 1000 || q_cyc.size() != 0) && cy < 20000) begin
      @(negedge clk);
      if (ram_en) en_cnt++;
      if (rvalid) begin
        vectors++;
        if (q_cyc.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious_rvalid: rvalid at cycle %0d with nothing outstanding", cy);
        end else begin
          c = q_cyc.pop_front();
          d = q_data.pop_front();
          if (cy !== c || rdata !== d) begin
            miscompares++;
            $display("FAIL b2b_response: cycle %0d rdata %h, required cycle %0d rdata %h", cy, rdata, c, d);
          end
        end
      end
      g = gnt;
      if (gnt) begin
        vectors++;
        if (cy < busy_until) begin
          miscompares++;
          $display("FAIL b2b_gnt_in_busy: gnt at cycle %0d, required none before %0d", cy, busy_until);
        end
        n = exp_nseg(be);
        en_exp += n;
        if (n == 0) n = 1;
        mk = bytes_of(be);
        if (we) begin
          sb_mem[addr[7:2]] = (sb_mem[addr[7:2]] & ~mk) | (wdata & mk);
          d = 32'h0;
        end else begin
          d = sb_mem[addr[7:2]] & mk;
        end
        q_cyc.push_back(cy + n);
        q_data.push_back(d);
        busy_until = cy + n;
        sent++;
      end
      @(posedge clk); #1;
      if (g) begin
        if (sent < 1000) begin
          addr = $urandom; we = 1'($urandom_range(0, 1)); be = 4'($urandom_range(0, 15)); wdata = $urandom;
        end else begin
          req = 1'b0;
        end
      end
      cy++;
    end
    vectors++;
    if (sent !== 1000 || q_cyc.size() !== 0) begin
      miscompares++;
      $display("FAIL b2b_completion: sent %0d outstanding %0d, required 1000 0", sent, q_cyc.size());
    end
    vectors++;
    if (en_cnt !== en_exp) begin
      miscompares++;
      $display("FAIL b2b_ram_en_count: got %0d required %0d", en_cnt, en_exp);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_split_write();
    test_sparse_read();
    test_zero_be();
    test_reset_inflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
